sockit_ghrd_input_pio_dbnc: RTL

- Parametrised Avalon-MM input PIO for the HPS lightweight bridge: button and switch inputs with N-stage synchroniser and per-channel debounce.
- Selectable edge detection (rising, falling or any), per-bit write-1-to-clear edge capture, and a masked, level-sensitive irq.
- Drop-in successor for the fixed 4-bit button PIO; adds a runtime-programmable debounce threshold register.

---
 rtl/sockit_ghrd_pio_pkg.sv | 28 ++
 rtl/sockit_ghrd_input_pio_dbnc_if.sv | 27 ++
 rtl/sockit_ghrd_pio_debounce.sv | 51 +++++
 rtl/sockit_ghrd_input_pio_dbnc.sv | 98 +++++++++
 4 files changed

// File: rtl/sockit_ghrd_pio_pkg.sv
// Shared constants for the debounced input PIO.
// Register word addresses and edge-type encodings.
package sockit_ghrd_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_RAW    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_THRESH = 3'd4;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  function automatic logic edge_hit(
    input int   etype,
    input logic new_val
  );
    logic hit;
    hit = 1'b1;
    if (etype == EDGE_RISING)
      hit = new_val;
    else if (etype == EDGE_FALLING)
      hit = !new_val;
    return hit;
  endfunction

endpackage

// File: rtl/sockit_ghrd_input_pio_dbnc_if.sv
// Avalon-MM slave bus bundle for the input PIO.
// Master drives the command, slave returns readdata.
interface sockit_ghrd_input_pio_dbnc_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/sockit_ghrd_pio_debounce.sv
// One input channel: synchroniser, debounce counter,
// stable flop and edge-event strobe.
module sockit_ghrd_pio_debounce
  import sockit_ghrd_pio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 20,
  parameter int EDGE_TYPE   = EDGE_FALLING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_in,
  input  logic [CNT_W-1:0] i_tm1,
  output logic             o_raw,
  output logic             o_stable,
  output logic             o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   w_diff;
  logic                   w_hit;

  assign o_raw    = r_sync[SYNC_STAGES-1];
  assign o_stable = r_stable;
  assign w_diff   = o_raw ^ r_stable;

  // >= so a threshold lowered mid-count fires at once
  assign w_hit  = w_diff && (r_cnt >= i_tm1);
  assign o_edge = w_hit && edge_hit(EDGE_TYPE, o_raw);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_hit) begin
        r_stable <= o_raw;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sockit_ghrd_input_pio_dbnc.sv
// Debounced input PIO: register file, read mux,
// sticky edge capture and masked level irq.
module sockit_ghrd_input_pio_dbnc
  import sockit_ghrd_pio_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 20,
  parameter int DEBOUNCE_RESET = 50000,
  parameter int EDGE_TYPE      = EDGE_FALLING
) (
  input  logic                         clk,
  input  logic                         reset_n,
  sockit_ghrd_input_pio_dbnc_if.slave  avs,
  input  logic [WIDTH-1:0]             in_port,
  output logic                         irq
);

  localparam logic [CNT_W-1:0] THR_RST =
    CNT_W'(DEBOUNCE_RESET);

  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [CNT_W-1:0] r_thr;
  logic [31:0]      r_rdata;

  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [CNT_W-1:0] w_tm1;
  logic [31:0]      w_rdata;
  logic             w_wr;
  logic             w_unused;

  assign w_unused = &{1'b0, avs.writedata};

  // zero threshold behaves as a one-cycle debounce
  assign w_tm1 = (r_thr == '0) ? '0 : r_thr - CNT_W'(1);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    sockit_ghrd_pio_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .EDGE_TYPE   (EDGE_TYPE)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_in     (in_port[gi]),
      .i_tm1    (w_tm1),
      .o_raw    (w_raw[gi]),
      .o_stable (w_stable[gi]),
      .o_edge   (w_edge[gi])
    );
  end

  assign w_wr  = avs.chipselect && !avs.write_n;
  assign w_clr = (w_wr && avs.address == ADDR_EDGE) ?
                 avs.writedata[WIDTH-1:0] : '0;

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      avs.address == ADDR_DATA:
        w_rdata[WIDTH-1:0] = w_stable;
      avs.address == ADDR_RAW:
        w_rdata[WIDTH-1:0] = w_raw;
      avs.address == ADDR_MASK:
        w_rdata[WIDTH-1:0] = r_mask;
      avs.address == ADDR_EDGE:
        w_rdata[WIDTH-1:0] = r_cap;
      avs.address == ADDR_THRESH:
        w_rdata[CNT_W-1:0] = r_thr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask  <= '0;
      r_cap   <= '0;
      r_thr   <= THR_RST;
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rdata;
      // new event wins over a same-cycle clear
      r_cap   <= (r_cap & ~w_clr) | w_edge;
      if (w_wr && avs.address == ADDR_MASK)
        r_mask <= avs.writedata[WIDTH-1:0];
      if (w_wr && avs.address == ADDR_THRESH)
        r_thr <= avs.writedata[CNT_W-1:0];
    end
  end

  assign avs.readdata = r_rdata;
  assign irq          = |(r_cap & r_mask);

endmodule
